fetch_stage: RTL

- Instruction fetch stage plus IF/ID pipeline register. Sits directly upstream of control_unit.
- Holds the PC and issues one-at-a-time requests to instruction memory.
- Buffers a returned instruction while decode is stalled.
- Presents inst_type/dir_mode/opcode fields straight to control_unit, and handles branch/jump redirects from execute.

---
 rtl/fetch_stage.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and one-entry skid buffer
// Single outstanding imem request; redirects flush IF/ID and drain any in-flight response.
module fetch_stage #(
  parameter int PC_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  imem_req,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic                  imem_rvalid,
  input  logic [INST_WIDTH-1:0] imem_rdata,
  output logic                  if_id_valid,
  output logic [INST_WIDTH-1:0] if_id_inst,
  output logic [PC_WIDTH-1:0]   if_id_pc,
  output logic [PC_WIDTH-1:0]   if_id_pc_plus4,
  output logic [1:0]            inst_type,
  output logic [1:0]            dir_mode,
  output logic [2:0]            opcode
);

  typedef enum logic [1:0] {IDLE, WAIT, FULL} state_t;

  state_t                state, state_nxt;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   req_pc;
  logic [PC_WIDTH-1:0]   buf_pc;
  logic [INST_WIDTH-1:0] buf_inst;
  logic                  drop;
  logic                  issue;
  logic                  load_resp;
  logic                  load_buf;
  logic                  fill_buf;
  logic                  outstanding_no_resp;

  assign outstanding_no_resp = (state == WAIT) && !imem_rvalid;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    load_resp = 1'b0;
    load_buf  = 1'b0;
    fill_buf  = 1'b0;
    if (redirect_valid) begin
      state_nxt = outstanding_no_resp ? WAIT : IDLE;
    end else begin
      case (state)
        IDLE: begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              state_nxt = IDLE;
            end else if (!stall || !if_id_valid) begin
              load_resp = 1'b1;
              issue     = 1'b1;
            end else begin
              fill_buf  = 1'b1;
              state_nxt = FULL;
            end
          end
        end
        FULL: begin
          if (!stall) begin
            load_buf  = 1'b1;
            issue     = 1'b1;
            state_nxt = WAIT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // IDLE requests combinationally, so hold the pulse low while reset is asserted
  assign imem_req  = issue & rst_n;
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_pc   <= '0;
      buf_pc   <= '0;
      buf_inst <= '0;
      drop     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else if (issue) begin
        pc <= pc + PC_WIDTH'(4);
      end
      if (issue) begin
        req_pc <= pc;
      end
      if (fill_buf) begin
        buf_inst <= imem_rdata;
        buf_pc   <= req_pc;
      end
      // one flag suffices: never more than one request in flight
      if (redirect_valid) begin
        drop <= outstanding_no_resp;
      end else if (state == WAIT && imem_rvalid) begin
        drop <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid    <= 1'b0;
      if_id_inst     <= '0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= '0;
    end else if (redirect_valid) begin
      if_id_valid <= 1'b0;
    end else if (load_resp) begin
      if_id_valid    <= 1'b1;
      if_id_inst     <= imem_rdata;
      if_id_pc       <= req_pc;
      if_id_pc_plus4 <= req_pc + PC_WIDTH'(4);
    end else if (load_buf) begin
      if_id_valid    <= 1'b1;
      if_id_inst     <= buf_inst;
      if_id_pc       <= buf_pc;
      if_id_pc_plus4 <= buf_pc + PC_WIDTH'(4);
    end else if (!stall) begin
      // decode consumed the instruction and nothing new arrived: present a bubble
      if_id_valid <= 1'b0;
    end
  end

  always_comb begin
    inst_type = 2'b00;
    dir_mode  = 2'b00;
    opcode    = 3'b111;
    if (if_id_valid) begin
      inst_type = if_id_inst[31:30];
      dir_mode  = if_id_inst[29:28];
      opcode    = if_id_inst[27:25];
    end
  end

endmodule
